// File: rtl/card_datapath_if.sv
// Controller-to-datapath bundle: card/load strobes toward the datapath,
// scores, player third card and 7-segment drives back.
interface card_datapath_if;
    logic [3:0] new_card;
    logic       load_pcard1;
    logic       load_pcard2;
    logic       load_pcard3;
    logic       load_dcard1;
    logic       load_dcard2;
    logic       load_dcard3;
    logic [3:0] pscore_out;
    logic [3:0] dscore_out;
    logic [3:0] pcard3_out;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output new_card, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
        input  pscore_out, dscore_out, pcard3_out,
               HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  new_card, load_pcard1, load_pcard2, load_pcard3,
               load_dcard1, load_dcard2, load_dcard3,
        output pscore_out, dscore_out, pcard3_out,
               HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/card_datapath.sv
// Baccarat hand datapath: six card registers, mod-10 hand scores and
// active-low 7-segment decode of each held card.
module card_datapath (
    input  logic            slow_clock,
    input  logic            resetb,
    card_datapath_if.slave  bus
);

    logic [5:0] w_load;
    logic [3:0] w_card_in;
    logic [3:0] r_card [6];
    logic [4:0] w_psum;
    logic [4:0] w_dsum;

    function automatic logic [3:0] card_value(input logic [3:0] c);
        return (c <= 4'd9) ? c : 4'd0;
    endfunction

    function automatic logic [3:0] mod10(input logic [4:0] s);
        logic [4:0] r;
        if (s >= 5'd20)      r = s - 5'd20;
        else if (s >= 5'd10) r = s - 5'd10;
        else                 r = s;
        return r[3:0];
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'd1:    s = 7'b0001000;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd10:   s = 7'b1000000;
            4'd11:   s = 7'b1100001;
            4'd12:   s = 7'b0011000;
            4'd13:   s = 7'b0001001;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_load = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                     bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

    // Illegal codes 0/14/15 are stored as empty so every downstream decode sees 0.
    assign w_card_in = (bus.new_card >= 4'd1 && bus.new_card <= 4'd13) ? bus.new_card : 4'd0;

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int unsigned i = 0; i < 6; i++) r_card[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 6; i++)
                if (w_load[i]) r_card[i] <= w_card_in;
        end
    end

    assign w_psum = 5'(card_value(r_card[0])) + 5'(card_value(r_card[1]))
                  + 5'(card_value(r_card[2]));
    assign w_dsum = 5'(card_value(r_card[3])) + 5'(card_value(r_card[4]))
                  + 5'(card_value(r_card[5]));

    assign bus.pscore_out = mod10(w_psum);
    assign bus.dscore_out = mod10(w_dsum);
    assign bus.pcard3_out = r_card[2];

    assign bus.HEX0 = seg(r_card[0]);
    assign bus.HEX1 = seg(r_card[1]);
    assign bus.HEX2 = seg(r_card[2]);
    assign bus.HEX3 = seg(r_card[3]);
    assign bus.HEX4 = seg(r_card[4]);
    assign bus.HEX5 = seg(r_card[5]);

endmodule

// File: tb/tb_card_datapath.sv
// Bench for card_datapath: vector table with expected scores/one display,
// queued as each strobe is driven and checked after the capturing edge.
module tb_card_datapath;

    logic slow_clock = 1'b0;
    logic resetb     = 1'b0;

    card_datapath_if bus ();

    card_datapath dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .bus        (bus)
    );

    always #5 slow_clock = ~slow_clock;

    // load bits: {d3,d2,d1,p3,p2,p1}
    typedef struct {
        logic       pre_reset;
        logic [5:0] load;
        logic [3:0] card;
        logic [3:0] exp_p;
        logic [3:0] exp_d;
        logic [3:0] exp_pc3;
        int         hex_idx;
        logic [6:0] exp_hex;
    } vec_t;

    vec_t vecs [19];
    vec_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [6:0] hex_of(input int idx);
        case (idx)
            0: return bus.HEX0;
            1: return bus.HEX1;
            2: return bus.HEX2;
            3: return bus.HEX3;
            4: return bus.HEX4;
            default: return bus.HEX5;
        endcase
    endfunction

    task automatic drive(input logic [5:0] ld, input logic [3:0] c);
        {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
         bus.load_pcard3, bus.load_pcard2, bus.load_pcard1} = ld;
        bus.new_card = c;
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, "_pscore"}, 7'(bus.pscore_out), 7'd0);
        check({tag, "_dscore"}, 7'(bus.dscore_out), 7'd0);
        check({tag, "_pcard3"}, 7'(bus.pcard3_out), 7'd0);
        for (int h = 0; h < 6; h++)
            check($sformatf("%s_hex%0d", tag, h), hex_of(h), 7'b1111111);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 6'b000001, 4'd7,  4'd7, 4'd0, 4'd0,  0, 7'b1111000};
        vecs[1]  = '{1'b0, 6'b000010, 4'd8,  4'd5, 4'd0, 4'd0,  1, 7'b0000000};
        vecs[2]  = '{1'b0, 6'b001000, 4'd13, 4'd5, 4'd0, 4'd0,  3, 7'b0001001};
        vecs[3]  = '{1'b0, 6'b010000, 4'd12, 4'd5, 4'd0, 4'd0,  4, 7'b0011000};
        vecs[4]  = '{1'b0, 6'b000001, 4'd9,  4'd7, 4'd0, 4'd0,  0, 7'b0010000};
        vecs[5]  = '{1'b0, 6'b000010, 4'd9,  4'd8, 4'd0, 4'd0,  1, 7'b0010000};
        vecs[6]  = '{1'b0, 6'b000100, 4'd9,  4'd7, 4'd0, 4'd9,  2, 7'b0010000};
        vecs[7]  = '{1'b1, 6'b001001, 4'd4,  4'd4, 4'd4, 4'd0,  0, 7'b0011001};
        vecs[8]  = '{1'b0, 6'b100000, 4'd15, 4'd4, 4'd4, 4'd0,  5, 7'b1111111};
        vecs[9]  = '{1'b0, 6'b010000, 4'd10, 4'd4, 4'd4, 4'd0,  4, 7'b1000000};
        vecs[10] = '{1'b0, 6'b000100, 4'd11, 4'd4, 4'd4, 4'd11, 2, 7'b1100001};
        vecs[11] = '{1'b0, 6'b000010, 4'd5,  4'd9, 4'd4, 4'd11, 1, 7'b0010010};
        vecs[12] = '{1'b0, 6'b100000, 4'd6,  4'd9, 4'd0, 4'd11, 5, 7'b0000010};
        vecs[13] = '{1'b0, 6'b000010, 4'd1,  4'd5, 4'd0, 4'd11, 1, 7'b0001000};
        vecs[14] = '{1'b0, 6'b000100, 4'd3,  4'd8, 4'd0, 4'd3,  2, 7'b0110000};
        vecs[15] = '{1'b0, 6'b100000, 4'd2,  4'd8, 4'd6, 4'd3,  5, 7'b0100100};
        vecs[16] = '{1'b0, 6'b001000, 4'd14, 4'd8, 4'd2, 4'd3,  3, 7'b1111111};
        vecs[17] = '{1'b0, 6'b001000, 4'd0,  4'd8, 4'd2, 4'd3,  3, 7'b1111111};
        vecs[18] = '{1'b0, 6'b000000, 4'd9,  4'd8, 4'd2, 4'd3,  0, 7'b0011001};

        drive(6'b000000, 4'd0);
        resetb = 1'b0;
        @(posedge slow_clock);
        #1;
        check_all_clear("reset");
        @(negedge slow_clock);
        resetb = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].pre_reset) begin
                @(negedge slow_clock);
                resetb = 1'b0;
                #1;
                resetb = 1'b1;
            end
            @(negedge slow_clock);
            drive(vecs[i].load, vecs[i].card);
            sb_q.push_back(vecs[i]);
            @(posedge slow_clock);
            #1;
            drive(6'b000000, 4'd0);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_empty vec%0d: got empty queue expected entry", i);
            end else begin
                vec_t e;
                e = sb_q.pop_front();
                check($sformatf("v%0d_pscore", i), 7'(bus.pscore_out), 7'(e.exp_p));
                check($sformatf("v%0d_dscore", i), 7'(bus.dscore_out), 7'(e.exp_d));
                check($sformatf("v%0d_pcard3", i), 7'(bus.pcard3_out), 7'(e.exp_pc3));
                check($sformatf("v%0d_hex%0d", i, e.hex_idx), hex_of(e.hex_idx), e.exp_hex);
            end
        end

        // Async reset mid-cycle while a load strobe is high: clears at once and
        // the following edge still sees reset, so the load is ignored.
        @(negedge slow_clock);
        drive(6'b000010, 4'd7);
        #2;
        resetb = 1'b0;
        #1;
        check_all_clear("async_rst");
        @(posedge slow_clock);
        #1;
        check("rst_prio_hex1", bus.HEX1, 7'b1111111);
        check("rst_prio_pscore", 7'(bus.pscore_out), 7'd0);
        @(negedge slow_clock);
        drive(6'b000000, 4'd0);
        resetb = 1'b1;

        // Load accepted again after release.
        @(negedge slow_clock);
        drive(6'b000010, 4'd7);
        @(posedge slow_clock);
        #1;
        drive(6'b000000, 4'd0);
        check("post_rst_hex1", bus.HEX1, 7'b1111000);
        check("post_rst_pscore", 7'(bus.pscore_out), 7'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
